// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter.
// Optional packet lock is enabled by defining ARB_PKT_LOCK_EN.
package arb_pkg;

   typedef enum logic {
      ARB_IDLE  = 1'b0,
      ARB_GRANT = 1'b1
   } arb_state_t;

   // Index after idx in a ring of num entries, wrapping num-1 back to 0.
   function automatic int unsigned rr_next_idx(input int unsigned idx, input int unsigned num);
      if (idx >= (num - 32'd1)) begin
         return 32'd0;
      end else begin
         return idx + 32'd1;
      end
   endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational rotated first-one search: lowest index at or after ptr
// (wrapping) whose request bit is set.
module rr_priority_pick
   import arb_pkg::*;
#(
   parameter int NUM_INPUTS = 8,
   localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [SEL_WIDTH-1:0]  ptr,
   output logic [SEL_WIDTH-1:0]  idx,
   output logic                  found
);

   int unsigned cand_s;

   // Walk offsets from farthest to nearest so the nearest hit is written last.
   always_comb begin
      idx    = {SEL_WIDTH{1'b0}};
      found  = 1'b0;
      cand_s = 32'd0;
      for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
         cand_s = (32'(ptr) + 32'(k)) % 32'(NUM_INPUTS);
         if (req[cand_s]) begin
            idx   = SEL_WIDTH'(cand_s);
            found = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter driving the select of a downstream data mux.
// Define ARB_PKT_LOCK_EN to hold the grant until the packet's LAST beat.
module rr_mux_arbiter
   import arb_pkg::*;
#(
   parameter int NUM_INPUTS = 8,
   localparam int SEL_WIDTH = $clog2(NUM_INPUTS)
) (
   input  logic                  CLK,
   input  logic                  RSTN,
   input  logic [NUM_INPUTS-1:0] REQ_IN,
   input  logic [NUM_INPUTS-1:0] LAST_IN,
   input  logic                  READY_IN,
   output logic                  VALID_OUT,
   output logic [SEL_WIDTH-1:0]  SEL_OUT,
   output logic [NUM_INPUTS-1:0] ACK_OUT
);

   if (NUM_INPUTS < 2) begin : g_bad_num_inputs
      $error("rr_mux_arbiter: NUM_INPUTS must be at least 2");
   end

   arb_state_t              state_r;
   arb_state_t              state_nxt_s;
   logic [SEL_WIDTH-1:0]    sel_r;
   logic [SEL_WIDTH-1:0]    sel_nxt_s;
   logic [SEL_WIDTH-1:0]    ptr_r;
   logic [SEL_WIDTH-1:0]    ptr_nxt_s;
   logic [SEL_WIDTH-1:0]    pick_idx_s;
   logic                    pick_found_s;
   logic                    valid_s;
   logic                    xfer_s;
   logic [NUM_INPUTS-1:0]   ack_s;

   rr_priority_pick #(
      .NUM_INPUTS(NUM_INPUTS)
   ) u_pick (
      .req   (REQ_IN),
      .ptr   (ptr_r),
      .idx   (pick_idx_s),
      .found (pick_found_s)
   );

   // Valid follows the granted request directly so a dropped request is visible at once.
   assign valid_s   = (state_r == ARB_GRANT) && REQ_IN[sel_r];
   assign xfer_s    = valid_s && READY_IN;
   assign VALID_OUT = valid_s;
   assign SEL_OUT   = sel_r;
   assign ACK_OUT   = ack_s;

`ifndef ARB_PKT_LOCK_EN
   logic unused_last_s;
   assign unused_last_s = ^LAST_IN;
`endif

   // One-hot acknowledge to the granted source on the transfer cycle.
   always_comb begin
      ack_s = {NUM_INPUTS{1'b0}};
      if (xfer_s) begin
         ack_s[sel_r] = 1'b1;
      end else begin
         ack_s = {NUM_INPUTS{1'b0}};
      end
   end

   // Next-state, next-select and next-pointer decisions.
   always_comb begin
      state_nxt_s = state_r;
      sel_nxt_s   = sel_r;
      ptr_nxt_s   = ptr_r;
      case (state_r)
         ARB_IDLE: begin
            if (pick_found_s) begin
               sel_nxt_s   = pick_idx_s;
               state_nxt_s = ARB_GRANT;
            end else begin
               state_nxt_s = ARB_IDLE;
            end
         end
         ARB_GRANT: begin
            if (xfer_s) begin
`ifdef ARB_PKT_LOCK_EN
               if (LAST_IN[sel_r]) begin
                  ptr_nxt_s   = SEL_WIDTH'(rr_next_idx(32'(sel_r), 32'(NUM_INPUTS)));
                  state_nxt_s = ARB_IDLE;
               end else begin
                  state_nxt_s = ARB_GRANT;
               end
`else
               ptr_nxt_s   = SEL_WIDTH'(rr_next_idx(32'(sel_r), 32'(NUM_INPUTS)));
               state_nxt_s = ARB_IDLE;
`endif
            end else begin
               state_nxt_s = ARB_GRANT;
            end
         end
         default: begin
            state_nxt_s = ARB_IDLE;
         end
      endcase
   end

   // State, select and round-robin pointer registers.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_r <= ARB_IDLE;
         sel_r   <= {SEL_WIDTH{1'b0}};
         ptr_r   <= {SEL_WIDTH{1'b0}};
      end else begin
         state_r <= state_nxt_s;
         sel_r   <= sel_nxt_s;
         ptr_r   <= ptr_nxt_s;
      end
   end

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter (NUM_INPUTS=8) with a 16-bit data mux
// on SEL_OUT; follows ARB_PKT_LOCK_EN when defined.
module tb_rr_mux_arbiter;

`ifdef ARB_PKT_LOCK_EN
   localparam bit LOCK_EN = 1'b1;
`else
   localparam bit LOCK_EN = 1'b0;
`endif

   logic        CLK;
   logic        RSTN;
   logic [7:0]  REQ_IN;
   logic [7:0]  LAST_IN;
   logic        READY_IN;
   logic        VALID_OUT;
   logic [2:0]  SEL_OUT;
   logic [7:0]  ACK_OUT;

   logic [15:0] bus_in [8];
   logic [15:0] bus_out;

   int checks = 0;
   int errors = 0;

   // reference model: current owner (-1 when none), select and rotation pointer
   int m_owner;
   int m_sel;
   int m_ptr;

   logic [7:0]  pend;
   logic [7:0]  last_ack;
   logic        obs_valid;
   logic [2:0]  obs_sel;
   logic [7:0]  obs_ack;
   int          acked[$];
   int          beats2;

   rr_mux_arbiter #(.NUM_INPUTS(8)) dut (
      .CLK       (CLK),
      .RSTN      (RSTN),
      .REQ_IN    (REQ_IN),
      .LAST_IN   (LAST_IN),
      .READY_IN  (READY_IN),
      .VALID_OUT (VALID_OUT),
      .SEL_OUT   (SEL_OUT),
      .ACK_OUT   (ACK_OUT)
   );

   always_comb bus_out = bus_in[SEL_OUT];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      m_owner = -1;
      m_sel   = 0;
      m_ptr   = 0;
   endtask

   // One clock: compare at negedge against the model, then advance the model at posedge.
   task automatic cycle();
      logic       ev;
      logic [7:0] ea;
      bit         hit;
      @(negedge CLK);
      ev = (m_owner >= 0) ? REQ_IN[m_owner] : 1'b0;
      ea = (ev && READY_IN) ? (8'h01 << m_owner) : 8'h00;
      obs_valid = VALID_OUT;
      obs_sel   = SEL_OUT;
      obs_ack   = ACK_OUT;
      chk("valid", {31'd0, VALID_OUT}, {31'd0, ev});
      chk("sel", {29'd0, SEL_OUT}, 32'(m_sel));
      chk("ack", {24'd0, ACK_OUT}, {24'd0, ea});
      if (ACK_OUT != 8'h00) acked.push_back(int'(SEL_OUT));
      if (ea != 8'h00) chk("bus", {16'd0, bus_out}, {16'd0, bus_in[m_sel]});
      last_ack = ea;
      @(posedge CLK);
      if (m_owner < 0) begin
         hit = 1'b0;
         for (int k = 0; k < 8; k++) begin
            int c;
            c = (m_ptr + k) % 8;
            if (!hit && REQ_IN[c]) begin
               hit = 1'b1;
               m_owner = c;
               m_sel = c;
            end
         end
      end else if (ev && READY_IN) begin
         if (!(LOCK_EN && !LAST_IN[m_owner])) begin
            m_ptr = (m_owner + 1) % 8;
            m_owner = -1;
         end
      end
      #1;
   endtask

   task automatic run(input int n, input logic [7:0] persist);
      for (int i = 0; i < n; i++) begin
         REQ_IN = pend;
         cycle();
         pend = (pend & ~last_ack) | persist;
      end
   endtask

   task automatic chk_seq(input string tag, input int idx, input int exp_v);
      chk(tag, (idx < acked.size()) ? 32'(acked[idx]) : 32'hFFFF_FFFF, 32'(exp_v));
   endtask

   initial begin
      RSTN = 1'b0; REQ_IN = 8'hFF; LAST_IN = 8'h00; READY_IN = 1'b1;
      pend = 8'h00; last_ack = 8'h00; beats2 = 0;
      for (int i = 0; i < 8; i++) bus_in[i] = 16'($urandom);
      model_reset();

      // reset state with every source requesting
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      chk("rst_valid", {31'd0, VALID_OUT}, 32'd0);
      chk("rst_sel", {29'd0, SEL_OUT}, 32'd0);
      chk("rst_ack", {24'd0, ACK_OUT}, 32'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;

      // fairness: all requesting, consumer always ready
      acked.delete(); pend = 8'hFF;
      run(20, 8'hFF);
      for (int i = 0; i < 9; i++) chk_seq("fair_seq", i, i % 8);

      // wrap and skip: grant 5 leaves ptr at 6, then 0 and 2 requesting
      pend = 8'h20; run(4, 8'h00);
      acked.delete(); pend = 8'h05; run(6, 8'h00);
      chk("wrap_cnt", 32'(acked.size()), 32'd2);
      chk_seq("wrap_seq0", 0, 0);
      chk_seq("wrap_seq1", 1, 2);

      // backpressure on source 3
      pend = 8'h08; READY_IN = 1'b0; run(2, 8'h00);
      for (int i = 0; i < 5; i++) begin
         run(1, 8'h00);
         chk("bp_valid", {31'd0, obs_valid}, 32'd1);
         chk("bp_sel", {29'd0, obs_sel}, 32'd3);
         chk("bp_ack", {24'd0, obs_ack}, 32'd0);
      end
      READY_IN = 1'b1; run(1, 8'h00);
      chk("bp_ack_go", {24'd0, obs_ack}, 32'h08);
      run(1, 8'h00);
      chk("bp_ack_once", {24'd0, obs_ack}, 32'h00);

      // reset while source 4 is granted and stalled
      pend = 8'h10; READY_IN = 1'b0; run(2, 8'h00);
      REQ_IN = pend;
      RSTN = 1'b0; #1;
      chk("mr_valid", {31'd0, VALID_OUT}, 32'd0);
      chk("mr_sel", {29'd0, SEL_OUT}, 32'd0);
      chk("mr_ack", {24'd0, ACK_OUT}, 32'd0);
      model_reset();
      READY_IN = 1'b1;
      @(negedge CLK);
      chk("mr_ack_hold", {24'd0, ACK_OUT}, 32'd0);
      @(posedge CLK); #1;
      RSTN = 1'b1;
      acked.delete(); run(4, 8'h00);
      chk_seq("mr_rearb", 0, 4);

      // packet: source 2 sends three beats while source 1 keeps requesting
      pend = 8'h02; run(3, 8'h00);
      acked.delete(); beats2 = 0; pend = 8'h06;
      for (int i = 0; i < 14; i++) begin
         LAST_IN = (beats2 == 2) ? 8'h04 : 8'h00;
         REQ_IN = pend;
         cycle();
         if (last_ack[2]) beats2++;
         pend = (pend & ~last_ack) | 8'h02 | ((beats2 < 3) ? 8'h04 : 8'h00);
      end
      chk_seq("pkt_seq0", 0, 2);
      chk_seq("pkt_seq1", 1, LOCK_EN ? 2 : 1);
      chk_seq("pkt_seq2", 2, 2);
      chk_seq("pkt_seq3", 3, 1);

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         LAST_IN  = 8'($urandom);
         READY_IN = ($urandom_range(0, 3) != 0);
         REQ_IN = pend;
         cycle();
         pend = (pend & ~last_ack) | (8'($urandom) & 8'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
